alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised successor to the CPU datapath ALU. It keeps the A operand register and G result register so it plugs into the same bus-driven control unit. It adds:
- a 3-bit operation select covering arithmetic, logic and shift ops;
- a registered flag set;
- a multi-cycle shift-add multiplier with a busy/done handshake.

## Interface
Parameters:
- WIDTH, 16, datapath width; power of two, ≥ 4.

Ports:
- iClk  in  1  clock; all state updates on the rising edge.
- iRst_n  in  1  reset; asynchronous, active-low.
- iA  in  1  load A register from iRx.
- iG  in  1  execute iOp and capture the result into G; ignored while oBusy.
- iOp  in  3  operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 MUL.
- iRx  in  WIDTH  A-register load data.
- iRy  in  WIDTH  second operand (B).
- oResult  out  WIDTH  G register.
- oFlags  out  4  {Z,N,C,V}, registered, updated with G.
- oBusy  out  1  multiply in progress.
- oDone  out  1  one-cycle pulse after G is written.

## Operation
- A register:
  - loads iRx on any edge with iA=1, including while oBusy;
  - holds otherwise.
- Single-cycle ops are executed on the edge with iG=1, in IDLE, and iOp≠MUL. The result uses the current A and iRy.
  - ADD: A+B. C = carry out. V = signed overflow.
  - SUB: A+~B+1. C = carry out (1 when A ≥ B unsigned). V = signed overflow.
  - AND, OR, XOR: bitwise. C=0, V=0.
  - SHL, SHR: shift amount is iRy[$clog2(WIDTH)-1:0]; upper bits of iRy are ignored. C=0, V=0.
  - All ops: Z = (result==0). N = result[WIDTH-1].
- MUL is unsigned and returns the low WIDTH bits of the product.
  - Flags: Z and N from the result. C = 1 if any high product bit is nonzero. V=0.
- FSM states: IDLE, BUSY.
  - IDLE → BUSY on iG=1 with iOp=MUL. At that edge, latch mcand=A, mplier=iRy, acc=0, cnt=0.
  - Each BUSY cycle:
    - if mplier[0]: acc += mcand (2·WIDTH bits);
    - mcand <<= 1;
    - mplier >>= 1;
    - cnt++.
  - BUSY → IDLE when cnt reaches WIDTH-1 on an edge. On that same edge, G ← acc[WIDTH-1:0] (including that cycle's add) and flags are updated.
- While BUSY:
  - iG and iOp are ignored; the request is not queued.
  - G and flags hold their previous values.
- Reset is asynchronous and can occur at any time, including mid-multiply. It forces:
  - state=IDLE;
  - A, G, oFlags, acc, cnt = 0;
  - oBusy=0, oDone=0.
- No op writes A. Nothing writes iRy.

## Timing
- Reset values: oResult=0, oFlags=4'b0000, oBusy=0, oDone=0.
- Single-cycle op:
  - G and flags are valid after the edge that samples iG.
  - oDone is high for the following cycle only.
- MUL:
  - oBusy rises after the start edge and stays high for exactly WIDTH cycles.
  - G is written on the WIDTH-th edge after the start edge; oDone pulses in the cycle after.
- Back-to-back: iG may be reasserted in the cycle oDone is high; the new op executes on that edge.
- Simultaneous iA and iG on one edge: the op uses the old A. A takes iRx on the same edge.

## Structure
- Shared package alu_pkg:
  - op-code localparams (OP_ADD … OP_MUL);
  - flag bit indices (FLAG_Z=3, FLAG_N=2, FLAG_C=1, FLAG_V=0);
  - FSM state encoding.
- One sub-module, addsub_n: parametrised WIDTH adder/subtractor with carry-out and overflow outputs. It is instantiated once for ADD/SUB.
- The multiplier's accumulate is a separate 2·WIDTH adder inline.

## Test plan
All scenarios use WIDTH=16.
- Reset: hold iRst_n=0 mid-stream → oResult=0x0000, oFlags=0000, oBusy=0, oDone=0, asynchronously (before the next edge).
- ADD: A=0x7FFF, iRy=0x0001 → G=0x8000, flags Z0 N1 C0 V1. SUB: A=0x0005, iRy=0x0005 → G=0x0000, Z1 N0 C1 V0. Each gives a one-cycle oDone.
- SHL: A=0x0001, iRy=0x0013 → G=0x0008 (amount 3). SHR: A=0x8000, iRy=0x000F → G=0x0001.
- MUL: A=0x0123, iRy=0x0045 → oBusy high for 16 cycles, then G=0x4E6F, C=0. MUL: A=0x0100, iRy=0x0100 → G=0x0000, Z1 C1.
- During BUSY:
  - pulse iG with op ADD → ignored; G unchanged until the MUL completes;
  - load A=0xFFFF via iA → MUL result unaffected, and A=0xFFFF afterwards.
- Reset after 8 BUSY cycles → IDLE, G=0, oBusy=0. A subsequent MUL 0x0003×0x0004 completes normally with G=0x000C.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: op-codes, flag bit positions and FSM states shared by the alu_seq files
package alu_pkg;
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
    typedef enum logic {ST_IDLE, ST_BUSY} state_t;
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: control/data bus of alu_seq
// ports: iA (load A), iG (execute), iOp, iRx (A data), iRy (B operand) -> DUT;
//        oResult (G), oFlags {Z,N,C,V}, oBusy, oDone <- DUT
interface alu_seq_if #(parameter int WIDTH = 16);
    logic             iA;
    logic             iG;
    logic [2:0]       iOp;
    logic [WIDTH-1:0] iRx;
    logic [WIDTH-1:0] iRy;
    logic [WIDTH-1:0] oResult;
    logic [3:0]       oFlags;
    logic             oBusy;
    logic             oDone;
    modport master (output iA, iG, iOp, iRx, iRy, input oResult, oFlags, oBusy, oDone);
    modport slave  (input iA, iG, iOp, iRx, iRy, output oResult, oFlags, oBusy, oDone);
endinterface

// File: rtl/addsub_n.sv
// addsub_n: WIDTH-bit adder/subtractor with carry-out and signed overflow
// ports: i_a, i_b operands; i_sub selects a+~b+1; o_sum result; o_c carry out; o_v overflow
module addsub_n #(parameter int WIDTH = 16) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_c,
    output logic             o_v
);
    logic [WIDTH-1:0] w_b;
    assign w_b = i_sub ? ~i_b : i_b;
    assign {o_c, o_sum} = {1'b0, i_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, i_sub};
    // overflow: both addends share a sign that the sum does not
    assign o_v = (i_a[WIDTH-1] == w_b[WIDTH-1]) && (o_sum[WIDTH-1] != i_a[WIDTH-1]);
endmodule

// File: rtl/alu_seq.sv
// alu_seq: A/G register ALU with registered flags and a shift-add multiplier
// ports: iClk clock; iRst_n async active-low reset; bus (alu_seq_if.slave) carries
//        iA/iG/iOp/iRx/iRy in and oResult/oFlags/oBusy/oDone out
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input logic       iClk,
    input logic       iRst_n,
    alu_seq_if.slave  bus
);
    localparam int SW = $clog2(WIDTH);
    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_g;
    logic [3:0]         r_flags;
    logic               r_done;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [SW-1:0]      r_cnt;
    logic [WIDTH-1:0]   w_as_sum;
    logic               w_as_c;
    logic               w_as_v;
    logic [WIDTH-1:0]   w_res;
    logic               w_c;
    logic               w_v;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic               w_start;
    logic               w_exec;
    logic               w_finish;
    logic [WIDTH-1:0]   w_fres;
    logic [3:0]         w_flags;
    logic [SW-1:0]      w_amt;

    addsub_n #(.WIDTH(WIDTH)) u_addsub (
        .i_a   (r_a),
        .i_b   (bus.iRy),
        .i_sub (bus.iOp == OP_SUB),
        .o_sum (w_as_sum),
        .o_c   (w_as_c),
        .o_v   (w_as_v)
    );

    assign w_amt = bus.iRy[SW-1:0];
    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (bus.iOp)
            OP_ADD, OP_SUB: begin
                w_res = w_as_sum;
                w_c   = w_as_c;
                w_v   = w_as_v;
            end
            OP_AND:  w_res = r_a & bus.iRy;
            OP_OR:   w_res = r_a | bus.iRy;
            OP_XOR:  w_res = r_a ^ bus.iRy;
            OP_SHL:  w_res = r_a << w_amt;
            OP_SHR:  w_res = r_a >> w_amt;
            default: w_res = '0;
        endcase
    end

    // next state and the strobes that steer the datapath
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_exec      = 1'b0;
        w_finish    = 1'b0;
        if (r_state == ST_IDLE) begin
            w_start = bus.iG && (bus.iOp == OP_MUL);
            w_exec  = bus.iG && (bus.iOp != OP_MUL);
            w_state_nxt = w_start ? ST_BUSY : ST_IDLE;
        end else if (r_cnt == SW'(WIDTH - 1)) begin
            w_finish    = 1'b1;
            w_state_nxt = ST_IDLE;
        end
    end

    // the final multiply step writes G with this cycle's add folded in
    always_comb begin
        w_fres          = w_finish ? w_acc_nxt[WIDTH-1:0] : w_res;
        w_flags         = '0;
        w_flags[FLAG_Z] = (w_fres == '0);
        w_flags[FLAG_N] = w_fres[WIDTH-1];
        w_flags[FLAG_C] = w_finish ? |w_acc_nxt[2*WIDTH-1:WIDTH] : w_c;
        w_flags[FLAG_V] = w_finish ? 1'b0 : w_v;
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_a      <= '0;
            r_g      <= '0;
            r_flags  <= '0;
            r_done   <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else begin
            if (bus.iA) r_a <= bus.iRx;
            r_done <= w_exec | w_finish;
            if (w_exec || w_finish) begin
                r_g     <= w_fres;
                r_flags <= w_flags;
            end
            if (w_start) begin
                r_mcand  <= {{WIDTH{1'b0}}, r_a};
                r_mplier <= bus.iRy;
                r_acc    <= '0;
                r_cnt    <= '0;
            end else if (r_state == ST_BUSY) begin
                r_acc    <= w_acc_nxt;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.oResult = r_g;
    assign bus.oFlags  = r_flags;
    assign bus.oBusy   = (r_state == ST_BUSY);
    assign bus.oDone   = r_done;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed checks of alu_seq at WIDTH=16
module tb_alu_seq;
    import alu_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int passed = 0;
    int n;
    alu_seq_if #(.WIDTH(16)) bus ();
    alu_seq #(.WIDTH(16)) dut (.iClk(clk), .iRst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input logic [15:0] v);
        bus.iA = 1'b1;
        bus.iRx = v;
        step();
        bus.iA = 1'b0;
    endtask

    task automatic op(input logic [2:0] opc, input logic [15:0] ry);
        bus.iG = 1'b1;
        bus.iOp = opc;
        bus.iRy = ry;
        step();
        bus.iG = 1'b0;
    endtask

    task automatic wait_mul(output int cycles);
        cycles = 0;
        while (bus.oBusy && cycles < 40) begin
            step();
            cycles++;
        end
    endtask

    initial begin
        bus.iA = 0; bus.iG = 0; bus.iOp = OP_ADD; bus.iRx = 0; bus.iRy = 0;
        #2;
        chk("rst_result", bus.oResult, 0);
        chk("rst_flags", bus.oFlags, 0);
        chk("rst_busy", bus.oBusy, 0);
        chk("rst_done", bus.oDone, 0);
        @(negedge clk) rst_n = 1'b1;

        load_a(16'h7FFF);
        op(OP_ADD, 16'h0001);
        chk("add_g", bus.oResult, 16'h8000);
        chk("add_flags", bus.oFlags, 4'b0101);
        chk("add_done", bus.oDone, 1);
        step();
        chk("add_done_end", bus.oDone, 0);

        load_a(16'h0005);
        op(OP_SUB, 16'h0005);
        chk("sub_g", bus.oResult, 16'h0000);
        chk("sub_flags", bus.oFlags, 4'b1010);
        chk("sub_done", bus.oDone, 1);
        step();
        chk("sub_done_end", bus.oDone, 0);

        // op with simultaneous A load uses old A=5; next op issued while oDone high
        bus.iA = 1'b1; bus.iRx = 16'h0001;
        op(OP_SHL, 16'h0013);
        bus.iA = 1'b0;
        chk("shl_old_a", bus.oResult, 16'h0028);
        chk("b2b_done", bus.oDone, 1);
        op(OP_SHL, 16'h0013);
        chk("shl_g", bus.oResult, 16'h0008);
        chk("shl_flags", bus.oFlags, 4'b0000);
        chk("shl_done", bus.oDone, 1);

        load_a(16'h8000);
        op(OP_SHR, 16'h000F);
        chk("shr_g", bus.oResult, 16'h0001);

        load_a(16'h0123);
        op(OP_MUL, 16'h0045);
        chk("mul_busy_rise", bus.oBusy, 1);
        n = 0;
        while (bus.oBusy && n < 40) begin
            bus.iG = (n == 2);
            bus.iOp = (n == 2) ? OP_ADD : OP_MUL;
            bus.iA = (n == 5);
            bus.iRx = 16'hFFFF;
            if (n == 8) chk("mul_g_hold", bus.oResult, 16'h0001);
            step();
            n++;
        end
        bus.iG = 0; bus.iA = 0;
        chk("mul_cycles", n, 16);
        chk("mul_g", bus.oResult, 16'h4E6F);
        chk("mul_flags", bus.oFlags, 4'b0000);
        chk("mul_done", bus.oDone, 1);
        step();
        chk("mul_done_end", bus.oDone, 0);
        op(OP_OR, 16'h0000);
        chk("a_after_busy_load", bus.oResult, 16'hFFFF);
        chk("or_flags", bus.oFlags, 4'b0100);

        load_a(16'h0100);
        op(OP_MUL, 16'h0100);
        wait_mul(n);
        chk("mul2_cycles", n, 16);
        chk("mul2_g", bus.oResult, 16'h0000);
        chk("mul2_flags", bus.oFlags, 4'b1010);

        load_a(16'h0007);
        op(OP_ADD, 16'h0001);
        chk("pre_rst_g", bus.oResult, 16'h0008);
        op(OP_MUL, 16'h0003);
        for (int i = 0; i < 8; i++) step();
        chk("mid_busy", bus.oBusy, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_g", bus.oResult, 0);
        chk("arst_busy", bus.oBusy, 0);
        chk("arst_flags", bus.oFlags, 0);
        chk("arst_done", bus.oDone, 0);
        @(negedge clk) rst_n = 1'b1;
        step();
        chk("arst_stays_idle", bus.oBusy, 0);
        load_a(16'h0003);
        op(OP_MUL, 16'h0004);
        wait_mul(n);
        chk("mul3_cycles", n, 16);
        chk("mul3_g", bus.oResult, 16'h000C);
        chk("mul3_flags", bus.oFlags, 4'b0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
